// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl_pkg
// Brief    : Shared types for the 5-stage pipeline hazard controller:
//            memory-port states, next-PC select, opcode set, pipeline packet.
// Revision : 1.0 - initial release
// ============================================================================
package pipeline_hazard_ctrl_pkg;

   // Memory port handshake states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } mem_port_state_t;

   // Next-PC source
   typedef enum logic [1:0] {
      pc_plus4 = 2'd0,
      alu_out  = 2'd1,
      alu_mod2 = 2'd2
   } pcmux_sel_t;

   // RV32I major opcodes
   typedef enum logic [6:0] {
      op_lui   = 7'b0110111,
      op_auipc = 7'b0010111,
      op_jal   = 7'b1101111,
      op_jalr  = 7'b1100111,
      op_br    = 7'b1100011,
      op_load  = 7'b0000011,
      op_store = 7'b0100011,
      op_imm   = 7'b0010011,
      op_reg   = 7'b0110011
   } rv32i_opcode;

   // Control bits carried down the pipeline
   typedef struct packed {
      logic data_mem_read;
      logic data_mem_write;
   } ctrl_word_t;

   // Pipeline buffer contents seen by the controller
   typedef struct packed {
      rv32i_opcode opcode;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      ctrl_word_t  ctrl;
   } rv32i_packet_t;

   // Pipeline buffer indices into buf_load / buf_flush
   localparam int IFID  = 0;
   localparam int IDEX  = 1;
   localparam int EXMEM = 2;
   localparam int MEMWB = 3;

   // True when the instruction touches data memory
   function automatic logic is_mem_op(input ctrl_word_t c);
      return c.data_mem_read | c.data_mem_write;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl_if
// Brief    : Bundle between the hazard controller (master) and the datapath
//            plus memories (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface pipeline_hazard_ctrl_if
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int PERF_W = 32
);
   rv32i_packet_t     if_id;
   rv32i_packet_t     id_ex;
   rv32i_packet_t     ex_mem;
   logic              br_en;
   logic              inst_mem_resp;
   logic              data_mem_resp;
   logic              inst_mem_read;
   logic              data_mem_read;
   logic              data_mem_write;
   logic              pc_load;
   pcmux_sel_t        pcmux_sel;
   logic [3:0]        buf_load;
   logic [3:0]        buf_flush;
   logic [PERF_W-1:0] stall_cnt;
   logic [PERF_W-1:0] flush_cnt;
   logic              mem_timeout;

   modport master (
      input  if_id, id_ex, ex_mem, br_en, inst_mem_resp, data_mem_resp,
      output inst_mem_read, data_mem_read, data_mem_write, pc_load, pcmux_sel,
             buf_load, buf_flush, stall_cnt, flush_cnt, mem_timeout
   );

   modport slave (
      output if_id, id_ex, ex_mem, br_en, inst_mem_resp, data_mem_resp,
      input  inst_mem_read, data_mem_read, data_mem_write, pc_load, pcmux_sel,
             buf_load, buf_flush, stall_cnt, flush_cnt, mem_timeout
   );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_mem_port_fsm.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl_mem_port_fsm
// Brief    : One memory port handshake (IDLE -> REQ -> DONE -> REQ) with a
//            sticky response and a sticky wait-timeout flag.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl_mem_port_fsm
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int TIMEOUT_W   = 8,
   parameter int MEM_TIMEOUT = 200
) (
   input  wire logic clk,
   input  wire logic rst,
   input  wire logic needed,
   input  wire logic resp,
   input  wire logic adv,
   input  wire logic hold,
   output logic      req,
   output logic      done,
   output logic      timeout
);

   localparam logic [TIMEOUT_W-1:0] c_wait_last = TIMEOUT_W'(MEM_TIMEOUT - 1);

   mem_port_state_t      r_state;
   logic [TIMEOUT_W-1:0] r_wait;
   logic                 r_timeout;
   logic                 w_waiting;

   // An outstanding request that has not been answered this cycle
   assign w_waiting = (r_state == REQ) & needed & ~resp;

   // Handshake state, wait counter and sticky timeout
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= IDLE;
         r_wait    <= '0;
         r_timeout <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (needed) r_state <= REQ;
            // An unneeded port parks in IDLE so it neither requests nor waits
            REQ: begin
               if (!needed)   r_state <= IDLE;
               else if (resp) r_state <= (adv & ~hold) ? REQ : DONE;
            end
            DONE: if (adv & ~hold) r_state <= REQ;
            default: r_state <= IDLE;
         endcase

         if (w_waiting) begin
            if (r_wait != '1)          r_wait    <= r_wait + 1'b1;
            if (r_wait == c_wait_last) r_timeout <= 1'b1;
         end else begin
            r_wait <= '0;
         end
      end
   end

   assign req     = (r_state == REQ) & needed;
   assign done    = (r_state == DONE) | (req & resp);
   assign timeout = r_timeout;

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Brief    : 5-stage pipeline controller: decoupled instruction/data memory
//            handshakes, load-use stall, control-transfer redirect/flush,
//            saturating perf counters and memory timeout flag.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int PERF_W      = 32,
   parameter int TIMEOUT_W   = 8,
   parameter int MEM_TIMEOUT = 200,
   parameter bit LU_STALL_EN = 1'b1
) (
   input wire logic               clk,
   input wire logic               rst,
   pipeline_hazard_ctrl_if.master bus
);

   logic              w_data_needed;
   logic              w_inst_req, w_inst_done, w_inst_to;
   logic              w_data_req, w_data_done, w_data_to;
   logic              w_adv;
   logic              w_lu;
   logic              w_redirect;
   logic              w_stall;
   logic [PERF_W-1:0] r_stall_cnt;
   logic [PERF_W-1:0] r_flush_cnt;

   assign w_data_needed = is_mem_op(bus.ex_mem.ctrl);

   // Instruction port holds its fetched word across a load-use stall
   pipeline_hazard_ctrl_mem_port_fsm #(
      .TIMEOUT_W   (TIMEOUT_W),
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_inst_port (
      .clk     (clk),
      .rst     (rst),
      .needed  (1'b1),
      .resp    (bus.inst_mem_resp),
      .adv     (w_adv),
      .hold    (w_stall),
      .req     (w_inst_req),
      .done    (w_inst_done),
      .timeout (w_inst_to)
   );

   pipeline_hazard_ctrl_mem_port_fsm #(
      .TIMEOUT_W   (TIMEOUT_W),
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_data_port (
      .clk     (clk),
      .rst     (rst),
      .needed  (w_data_needed),
      .resp    (bus.data_mem_resp),
      .adv     (w_adv),
      .hold    (1'b0),
      .req     (w_data_req),
      .done    (w_data_done),
      .timeout (w_data_to)
   );

   assign w_adv = w_inst_done & (w_data_done | ~w_data_needed);

   assign w_lu = LU_STALL_EN & bus.id_ex.ctrl.data_mem_read & (bus.id_ex.rd != 5'd0) &
                 ((bus.id_ex.rd == bus.if_id.rs1) | (bus.id_ex.rd == bus.if_id.rs2));

   assign w_redirect = (bus.id_ex.opcode == op_jal) | (bus.id_ex.opcode == op_jalr) |
                       ((bus.id_ex.opcode == op_br) & bus.br_en);

   // Redirect wins so a stall never swallows a taken transfer
   assign w_stall = w_lu & ~w_redirect;

   // Buffer load/flush, PC load and next-PC select; everything frozen without ADV
   always_comb begin
      bus.buf_load  = 4'b0000;
      bus.buf_flush = 4'b0000;
      bus.pc_load   = 1'b0;
      bus.pcmux_sel = pc_plus4;
      if (w_adv) begin
         bus.buf_load = 4'b1111;
         bus.pc_load  = 1'b1;
         if (w_redirect) begin
            bus.buf_flush[IFID] = 1'b1;
            bus.buf_flush[IDEX] = 1'b1;
            bus.pcmux_sel       = (bus.id_ex.opcode == op_jalr) ? alu_mod2 : alu_out;
         end else if (w_stall) begin
            bus.buf_load[IFID]  = 1'b0;
            bus.buf_flush[IDEX] = 1'b1;
            bus.pc_load         = 1'b0;
         end
      end
   end

   // Saturating performance counters
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_adv & w_stall & (r_stall_cnt != '1))    r_stall_cnt <= r_stall_cnt + 1'b1;
         if (w_adv & w_redirect & (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
      end
   end

   assign bus.inst_mem_read  = w_inst_req;
   assign bus.data_mem_read  = w_data_req & bus.ex_mem.ctrl.data_mem_read;
   assign bus.data_mem_write = w_data_req & bus.ex_mem.ctrl.data_mem_write;
   assign bus.stall_cnt      = r_stall_cnt;
   assign bus.flush_cnt      = r_flush_cnt;
   assign bus.mem_timeout    = w_inst_to | w_data_to;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Brief    : Directed and randomized bench for pipeline_hazard_ctrl, compared
//            each cycle against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pipeline_hazard_ctrl;
   import pipeline_hazard_ctrl_pkg::*;

   localparam int PERF_W      = 4;
   localparam int MEM_TIMEOUT = 200;
   localparam int PERF_MAX    = (1 << PERF_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl_if #(.PERF_W(PERF_W)) bus ();

   pipeline_hazard_ctrl #(
      .PERF_W      (PERF_W),
      .TIMEOUT_W   (8),
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .LU_STALL_EN (1'b1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // port status: 0 = resting, 1 = request outstanding, 2 = answer held
   int m_ist, m_dst, m_iwait, m_dwait, m_stall, m_flush;
   bit m_timeout, m_last_adv;
   bit e_adv, e_lu, e_rdir, e_dn;
   bit e_iread, e_dread, e_dwrite, e_pcl;
   int e_sel, e_load, e_flush;

   task automatic model_reset();
      m_ist = 0; m_dst = 0; m_iwait = 0; m_dwait = 0;
      m_stall = 0; m_flush = 0; m_timeout = 0; m_last_adv = 0;
   endtask

   task automatic model_eval();
      bit idone, ddone;
      e_dn     = bus.ex_mem.ctrl.data_mem_read || bus.ex_mem.ctrl.data_mem_write;
      e_iread  = (m_ist == 1);
      e_dread  = (m_dst == 1) && bus.ex_mem.ctrl.data_mem_read;
      e_dwrite = (m_dst == 1) && bus.ex_mem.ctrl.data_mem_write;
      idone    = (m_ist == 2) || (m_ist == 1 && bus.inst_mem_resp);
      ddone    = (m_dst == 2) || (m_dst == 1 && e_dn && bus.data_mem_resp);
      e_adv    = idone && (ddone || !e_dn);
      e_lu     = bus.id_ex.ctrl.data_mem_read && bus.id_ex.rd != 0 &&
                 (bus.id_ex.rd == bus.if_id.rs1 || bus.id_ex.rd == bus.if_id.rs2);
      e_rdir   = bus.id_ex.opcode inside {op_jal, op_jalr} ||
                 (bus.id_ex.opcode == op_br && bus.br_en);
      e_load = 0; e_flush = 0; e_pcl = 0; e_sel = 0;
      if (e_adv) begin
         if (e_rdir) begin
            e_load = 15; e_flush = 3; e_pcl = 1;
            e_sel  = (bus.id_ex.opcode == op_jalr) ? 2 : 1;
         end else if (e_lu) begin
            e_load = 14; e_flush = 2; e_pcl = 0;
         end else begin
            e_load = 15; e_pcl = 1;
         end
      end
   endtask

   function automatic int port_next(int st, bit needed, bit resp, bit adv, bit hold);
      if (st == 0) return needed ? 1 : 0;
      if (st == 1) begin
         if (!needed) return 0;
         if (resp)    return (adv && !hold) ? 1 : 2;
         return 1;
      end
      return (adv && !hold) ? 1 : 2;
   endfunction

   task automatic model_update();
      if (!rst) begin
         model_reset();
         return;
      end
      if (m_ist == 1 && !bus.inst_mem_resp) m_iwait++; else m_iwait = 0;
      if (m_dst == 1 && e_dn && !bus.data_mem_resp) m_dwait++; else m_dwait = 0;
      if (m_iwait == MEM_TIMEOUT || m_dwait == MEM_TIMEOUT) m_timeout = 1;
      if (e_adv && e_rdir)      m_flush = (m_flush < PERF_MAX) ? m_flush + 1 : m_flush;
      else if (e_adv && e_lu)   m_stall = (m_stall < PERF_MAX) ? m_stall + 1 : m_stall;
      m_ist = port_next(m_ist, 1'b1, bus.inst_mem_resp, e_adv, e_lu && !e_rdir);
      m_dst = port_next(m_dst, e_dn, bus.data_mem_resp, e_adv, 1'b0);
      m_last_adv = e_adv;
   endtask

   // ---------------- stimulus helpers ----------------
   function automatic rv32i_packet_t mk(rv32i_opcode op, int rd, int rs1, int rs2);
      rv32i_packet_t p;
      p.opcode = op;
      p.rd     = 5'(rd);
      p.rs1    = 5'(rs1);
      p.rs2    = 5'(rs2);
      p.ctrl.data_mem_read  = (op == op_load);
      p.ctrl.data_mem_write = (op == op_store);
      return p;
   endfunction

   function automatic rv32i_packet_t rand_pkt();
      rv32i_opcode op;
      case ($urandom_range(0, 5))
         0:       op = op_load;
         1:       op = op_store;
         2:       op = op_br;
         3:       op = op_jal;
         4:       op = op_jalr;
         default: op = op_reg;
      endcase
      return mk(op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
   endfunction

   task automatic set_pkts(rv32i_packet_t a, rv32i_packet_t b, rv32i_packet_t c, bit br);
      bus.if_id  = a;
      bus.id_ex  = b;
      bus.ex_mem = c;
      bus.br_en  = br;
   endtask

   // Sample away from the edge and compare every output against the model
   task automatic sample();
      @(negedge clk);
      model_eval();
      check("inst_mem_read",  32'(bus.inst_mem_read),  32'(e_iread));
      check("data_mem_read",  32'(bus.data_mem_read),  32'(e_dread));
      check("data_mem_write", 32'(bus.data_mem_write), 32'(e_dwrite));
      check("pc_load",        32'(bus.pc_load),        32'(e_pcl));
      check("pcmux_sel",      32'(bus.pcmux_sel),      32'(e_sel));
      check("buf_load",       32'(bus.buf_load),       32'(e_load));
      check("buf_flush",      32'(bus.buf_flush),      32'(e_flush));
      check("stall_cnt",      32'(bus.stall_cnt),      32'(m_stall));
      check("flush_cnt",      32'(bus.flush_cnt),      32'(m_flush));
      check("mem_timeout",    32'(bus.mem_timeout),    32'(m_timeout));
   endtask

   task automatic advance();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      model_reset();
      sample();
      advance();
      rst = 1'b1;
   endtask

   rv32i_packet_t nop;

   initial begin
      nop = mk(op_reg, 0, 0, 0);
      set_pkts(nop, nop, nop, 1'b0);
      bus.inst_mem_resp = 1'b0;
      bus.data_mem_resp = 1'b0;
      model_reset();

      // Reset state
      sample();
      check("rst_buf_load", 32'(bus.buf_load), 32'h0);
      check("rst_pcmux",    32'(bus.pcmux_sel), 32'(pc_plus4));
      advance();
      rst = 1'b1;

      // No hazards: first request on cycle 2, advance on response
      sample(); check("c1_iread", 32'(bus.inst_mem_read), 32'd0); advance();
      sample(); check("c2_iread", 32'(bus.inst_mem_read), 32'd1); advance();
      bus.inst_mem_resp = 1'b1;
      sample(); check("nh_load", 32'(bus.buf_load), 32'hF); check("nh_pcl", 32'(bus.pc_load), 32'd1); advance();
      bus.inst_mem_resp = 1'b0;
      sample(); check("nh_rereq", 32'(bus.inst_mem_read), 32'd1); advance();

      // Skewed responses with a load in EX/MEM
      set_pkts(nop, nop, mk(op_load, 3, 1, 0), 1'b0);
      sample(); advance();
      bus.inst_mem_resp = 1'b1;
      sample(); check("sk_load_i", 32'(bus.buf_load), 32'h0); advance();
      bus.inst_mem_resp = 1'b0;
      for (int i = 0; i < 3; i++) begin
         sample();
         check("sk_iread", 32'(bus.inst_mem_read), 32'd0);
         check("sk_load",  32'(bus.buf_load), 32'h0);
         check("sk_dread", 32'(bus.data_mem_read), 32'd1);
         advance();
      end
      bus.data_mem_resp = 1'b1;
      sample(); check("sk_adv", 32'(bus.buf_load), 32'hF); advance();
      bus.data_mem_resp = 1'b0;
      set_pkts(nop, nop, nop, 1'b0);

      // Load-use: lw x5 then add x6,x5,x1
      set_pkts(mk(op_reg, 6, 5, 1), mk(op_load, 5, 2, 0), nop, 1'b0);
      bus.inst_mem_resp = 1'b1;
      sample();
      check("lu_load",  32'(bus.buf_load), 32'hE);
      check("lu_flush", 32'(bus.buf_flush), 32'h2);
      check("lu_pcl",   32'(bus.pc_load), 32'd0);
      advance();
      set_pkts(mk(op_reg, 6, 5, 1), nop, mk(op_load, 5, 2, 0), 1'b0);
      bus.inst_mem_resp = 1'b0;
      bus.data_mem_resp = 1'b1;
      sample();
      check("lu_cnt",   32'(bus.stall_cnt), 32'd1);
      check("lu_hold",  32'(bus.inst_mem_read), 32'd0);
      advance();
      bus.data_mem_resp = 1'b0;
      set_pkts(mk(op_reg, 6, 0, 1), mk(op_load, 0, 2, 0), nop, 1'b0);
      bus.inst_mem_resp = 1'b1;
      sample(); check("lu_x0_load", 32'(bus.buf_load), 32'hF); advance();
      set_pkts(nop, nop, nop, 1'b0);
      sample(); check("lu_x0_cnt", 32'(bus.stall_cnt), 32'd1); advance();

      // Redirects
      set_pkts(nop, mk(op_br, 0, 1, 2), nop, 1'b1);
      sample();
      check("br_sel",   32'(bus.pcmux_sel), 32'(alu_out));
      check("br_flush", 32'(bus.buf_flush), 32'h3);
      advance();
      set_pkts(nop, mk(op_jalr, 1, 2, 0), nop, 1'b0);
      sample();
      check("br_cnt",   32'(bus.flush_cnt), 32'd1);
      check("jalr_sel", 32'(bus.pcmux_sel), 32'(alu_mod2));
      advance();
      set_pkts(nop, mk(op_br, 0, 1, 2), nop, 1'b0);
      sample();
      check("nt_sel",   32'(bus.pcmux_sel), 32'(pc_plus4));
      check("nt_flush", 32'(bus.buf_flush), 32'h0);
      advance();

      // Randomized traffic; buffers only change after an advance
      for (int n = 0; n < 1500; n++) begin
         if (m_last_adv)
            set_pkts(rand_pkt(), rand_pkt(), rand_pkt(), 1'($urandom_range(0, 1)));
         bus.inst_mem_resp = ($urandom_range(0, 99) < 50);
         bus.data_mem_resp = ($urandom_range(0, 99) < 40);
         sample();
         advance();
      end

      // Timeout: instruction response withheld
      set_pkts(nop, nop, nop, 1'b0);
      bus.inst_mem_resp = 1'b0;
      bus.data_mem_resp = 1'b0;
      do_reset();
      sample(); advance();
      for (int i = 1; i <= MEM_TIMEOUT; i++) begin
         sample();
         if (i == MEM_TIMEOUT) check("to_early", 32'(bus.mem_timeout), 32'd0);
         advance();
      end
      sample(); check("to_set", 32'(bus.mem_timeout), 32'd1); advance();
      bus.inst_mem_resp = 1'b1;
      for (int i = 0; i < 3; i++) begin sample(); advance(); end
      check("to_sticky", 32'(bus.mem_timeout), 32'd1);

      // Asynchronous reset while the data port is requesting
      bus.inst_mem_resp = 1'b0;
      set_pkts(nop, nop, mk(op_store, 0, 1, 2), 1'b0);
      for (int i = 0; i < 3; i++) begin sample(); advance(); end
      check("ar_pre_dwrite", 32'(bus.data_mem_write), 32'd1);
      #2 rst = 1'b0;
      #1;
      model_reset();
      check("ar_iread",  32'(bus.inst_mem_read), 32'd0);
      check("ar_dwrite", 32'(bus.data_mem_write), 32'd0);
      check("ar_to",     32'(bus.mem_timeout), 32'd0);
      check("ar_cnt",    32'(bus.flush_cnt), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      sample(); check("ar_idle_d", 32'(bus.data_mem_write), 32'd0); advance();
      sample(); check("ar_req_d",  32'(bus.data_mem_write), 32'd1); advance();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Absolute bound on run time
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
`default_nettype wire
